mem_port_arbiter: RTL and testbench

//  Shares one single-port, fixed-latency unified memory between the fetch stage (IF) and the

---
 rtl/mem_port_arbiter_pkg.sv | 20 ++
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter_pick.sv | 23 ++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizes for the fetch / load-store memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int DATA_W_DEF     = 32;
  localparam int MEM_LAT_DEF    = 2;
  localparam int STARVE_MAX_DEF = 4;

  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t DONE  = 2'd3;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF port, D port, memory port and stall outputs of the arbiter.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  // The arbiter is the slave; the pipeline stages plus memory form the master side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational grant decision: D has priority unless IF has been starved STARVE_MAX times.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W      = 3
) (
  input  logic             ifReq,
  input  logic             dReq,
  input  logic [CNT_W-1:0] starveCnt,
  output logic             grantValid,
  output owner_t           grantOwner
);

  always_comb begin
    grantValid = ifReq | dReq;
    grantOwner = OWN_D;
    if (ifReq && (!dReq || (starveCnt == CNT_W'(STARVE_MAX)))) begin
      grantOwner = OWN_IF;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between fetch (IF) and load/store (D).
// Defining ARB_PERF_CNT_EN adds the perf_if_wait / perf_d_wait stall-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = MEM_LAT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_d_wait
`endif
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t            state;
  owner_t            owner;
  logic [LAT_W-1:0]  latCnt;
  logic [CNT_W-1:0]  starveCnt;
  logic              memEn;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic [DATA_W-1:0] ifRdata;
  logic [DATA_W-1:0] dRdata;
  logic              ifAck;
  logic              dAck;
  logic              isStore;
  logic              grantValid;
  owner_t            grantOwner;
  logic              stallIf;
  logic              stallMem;

  arb_pick #(
    .STARVE_MAX (STARVE_MAX),
    .CNT_W      (CNT_W)
  ) uPick (
    .ifReq      (bus.if_req),
    .dReq       (bus.d_req),
    .starveCnt  (starveCnt),
    .grantValid (grantValid),
    .grantOwner (grantOwner)
  );

  // mem_en and the acks are registered pulses, so each is high for exactly one FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= OWN_IF;
      latCnt   <= '0;
      memEn    <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifRdata  <= '0;
      dRdata   <= '0;
      ifAck    <= 1'b0;
      dAck     <= 1'b0;
      isStore  <= 1'b0;
    end else begin
      memEn <= 1'b0;
      memWe <= 1'b0;
      ifAck <= 1'b0;
      dAck  <= 1'b0;
      case (state)
        IDLE: begin
          if (grantValid) begin
            state <= ISSUE;
            owner <= grantOwner;
            memEn <= 1'b1;
            if (grantOwner == OWN_D) begin
              memWe    <= bus.d_we;
              memAddr  <= bus.d_addr;
              memWdata <= bus.d_wdata;
              isStore  <= bus.d_we;
            end else begin
              memAddr  <= bus.if_addr;
              memWdata <= '0;
              isStore  <= 1'b0;
            end
          end
        end
        ISSUE: begin
          latCnt <= LAT_W'(MEM_LAT - 1);
          state  <= WAIT;
        end
        WAIT: begin
          if (latCnt == '0) begin
            state <= DONE;
            if (owner == OWN_IF) begin
              ifRdata <= bus.mem_rdata;
              ifAck   <= 1'b1;
            end else begin
              if (!isStore) dRdata <= bus.mem_rdata;
              dAck <= 1'b1;
            end
          end else begin
            latCnt <= latCnt - LAT_W'(1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Starvation only accumulates while fetch is actually waiting behind D grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      starveCnt <= '0;
    end else if (!bus.if_req) begin
      starveCnt <= '0;
    end else if ((state == IDLE) && grantValid) begin
      if (grantOwner == OWN_IF) begin
        starveCnt <= '0;
      end else if (starveCnt != CNT_W'(STARVE_MAX)) begin
        starveCnt <= starveCnt + CNT_W'(1);
      end
    end
  end

  assign stallIf  = bus.if_req & ~ifAck;
  assign stallMem = bus.d_req & ~dAck;

  assign bus.if_rdata  = ifRdata;
  assign bus.if_ack    = ifAck;
  assign bus.d_rdata   = dRdata;
  assign bus.d_ack     = dAck;
  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.stall_if  = stallIf;
  assign bus.stall_mem = stallMem;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_wait <= '0;
      perf_d_wait  <= '0;
    end else begin
      if (stallIf)  perf_if_wait <= perf_if_wait + 32'd1;
      if (stallMem) perf_d_wait  <= perf_d_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: timestamp-level reference model plus directed scenarios.
// Build with ARB_PERF_CNT_EN defined to also cover the stall-cycle counters.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam int SLOTS      = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifReq, dReq, dWe;
  logic [31:0] ifAddr, dAddr, dWdata, memRdata;
  int          checkCount = 0;
  int          passCount  = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  assign bus.if_req    = ifReq;
  assign bus.if_addr   = ifAddr;
  assign bus.d_req     = dReq;
  assign bus.d_we      = dWe;
  assign bus.d_addr    = dAddr;
  assign bus.d_wdata   = dWdata;
  assign bus.mem_rdata = memRdata;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perfIfWait, perfDWait;
`endif

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_wait (perfIfWait),
    .perf_d_wait  (perfDWait)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  function automatic logic [31:0] initVal(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory contents: memArr is what the fake memory holds, memModel what the model believes.
  logic [31:0] memArr   [logic [31:0]];
  logic [31:0] memModel [logic [31:0]];
  bit          respValid [SLOTS];
  logic [31:0] respData  [SLOTS];
  int          cyc = 0;

  always @(negedge clk) begin : memoryProc
    if (bus.mem_en === 1'b1) begin
      if (bus.mem_we === 1'b1) begin
        memArr[bus.mem_addr] = bus.mem_wdata;
      end else begin
        respValid[(cyc + MEM_LAT) % SLOTS] = 1'b1;
        respData[(cyc + MEM_LAT) % SLOTS]  = memArr.exists(bus.mem_addr) ? memArr[bus.mem_addr] : initVal(bus.mem_addr);
      end
    end
  end

  always @(posedge clk) begin : memDriveProc
    int s;
    #1;
    s = cyc % SLOTS;
    if (respValid[s]) begin
      memRdata     = respData[s];
      respValid[s] = 1'b0;
    end else begin
      memRdata = 32'hBAD00000 | 32'(cyc);
    end
  end

  // Reference model: each grant schedules its strobe and ack at absolute cycle numbers.
  bit          schedEn [SLOTS], schedWe [SLOTS], schedIfAck [SLOTS], schedDAck [SLOTS], schedDLoad [SLOTS];
  logic [31:0] schedAddr [SLOTS], schedWdata [SLOTS], schedData [SLOTS];
  bit          modelLive = 1'b0;
  int          busyUntil, starve;
  bit          expEn, expWe, expIfAck, expDAck;
  logic [31:0] expAddr, expWdata, expIfRdata, expDRdata, perfIfM, perfDM;

  always @(posedge clk) begin : modelProc
    int s, a, nxt;
    bit grantIf;
    logic [31:0] ga;
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        schedEn[i] = 0; schedWe[i] = 0; schedIfAck[i] = 0; schedDAck[i] = 0; schedDLoad[i] = 0;
      end
      modelLive = 1'b1;
      busyUntil = cyc + 1;
      starve = 0;
      expEn = 0; expWe = 0; expIfAck = 0; expDAck = 0;
      expAddr = '0; expWdata = '0; expIfRdata = '0; expDRdata = '0;
      perfIfM = '0; perfDM = '0;
    end else if (modelLive) begin
      perfIfM = perfIfM + 32'(ifReq && !expIfAck);
      perfDM  = perfDM + 32'(dReq && !expDAck);
      if ((cyc >= busyUntil) && (ifReq || dReq)) begin
        grantIf = ifReq && (!dReq || (starve == STARVE_MAX));
        ga = grantIf ? ifAddr : dAddr;
        s = (cyc + 1) % SLOTS;
        a = (cyc + MEM_LAT + 2) % SLOTS;
        schedEn[s]    = 1'b1;
        schedWe[s]    = !grantIf && dWe;
        schedAddr[s]  = ga;
        schedWdata[s] = dWdata;
        schedData[a]  = memModel.exists(ga) ? memModel[ga] : initVal(ga);
        if (grantIf) begin
          schedIfAck[a] = 1'b1;
        end else begin
          schedDAck[a]  = 1'b1;
          schedDLoad[a] = !dWe;
          if (dWe) memModel[ga] = dWdata;
        end
        busyUntil = cyc + MEM_LAT + 3;
        starve = grantIf ? 0 : ((starve < STARVE_MAX) ? starve + 1 : starve);
      end
      if (!ifReq) starve = 0;
      nxt = (cyc + 1) % SLOTS;
      expEn = schedEn[nxt]; expWe = schedWe[nxt]; expAddr = schedAddr[nxt]; expWdata = schedWdata[nxt];
      expIfAck = schedIfAck[nxt]; expDAck = schedDAck[nxt];
      if (schedIfAck[nxt]) expIfRdata = schedData[nxt];
      if (schedDAck[nxt] && schedDLoad[nxt]) expDRdata = schedData[nxt];
      schedEn[nxt] = 0; schedWe[nxt] = 0; schedIfAck[nxt] = 0; schedDAck[nxt] = 0; schedDLoad[nxt] = 0;
    end
    cyc++;
  end

  always @(negedge clk) begin : compareProc
    if (modelLive) begin
      checkOutput("mem_en", bus.mem_en, expEn);
      if (expEn) begin
        checkOutput("mem_we", bus.mem_we, expWe);
        checkOutput("mem_addr", bus.mem_addr, expAddr);
        if (expWe) checkOutput("mem_wdata", bus.mem_wdata, expWdata);
      end
      checkOutput("if_ack", bus.if_ack, expIfAck);
      checkOutput("d_ack", bus.d_ack, expDAck);
      checkOutput("if_rdata", bus.if_rdata, expIfRdata);
      checkOutput("d_rdata", bus.d_rdata, expDRdata);
      checkOutput("stall_if", bus.stall_if, ifReq & ~expIfAck);
      checkOutput("stall_mem", bus.stall_mem, dReq & ~expDAck);
`ifdef ARB_PERF_CNT_EN
      checkOutput("perf_if_wait", perfIfWait, perfIfM);
      checkOutput("perf_d_wait", perfDWait, perfDM);
`endif
    end
  end

  int          enQ[$];
  logic        weQ[$];
  logic [31:0] addrQ[$], wdataQ[$];
  int          ifAckCyc, dAckCyc, dBeforeIf;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic iReq, input logic [31:0] iAddr, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [31:0] dwd);
    ifReq = iReq; ifAddr = iAddr; dReq = dr; dWe = dw; dAddr = da; dWdata = dwd;
  endtask

  // Requests are held until acked and re-raised the next cycle while transactions remain.
  task automatic runTraffic(input int nIf, input logic [31:0] ifA, input int nD, input logic dw,
                            input logic [31:0] dA, input logic [31:0] dWd);
    int ifDone = 0;
    int dDone  = 0;
    enQ.delete(); weQ.delete(); addrQ.delete(); wdataQ.delete();
    ifAckCyc = -1; dAckCyc = -1; dBeforeIf = -1;
    for (int c = 0; c < 200 && (ifDone < nIf || dDone < nD); c++) begin
      applyStimulus(ifDone < nIf, ifA + 32'(ifDone * 4), dDone < nD, dw, dA + 32'(dDone * 4), dWd + 32'(dDone));
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        enQ.push_back(c); weQ.push_back(bus.mem_we); addrQ.push_back(bus.mem_addr); wdataQ.push_back(bus.mem_wdata);
      end
      if (bus.if_ack === 1'b1) begin
        if (ifAckCyc < 0) begin ifAckCyc = c; dBeforeIf = dDone; end
        ifDone++;
      end
      if (bus.d_ack === 1'b1) begin
        if (dAckCyc < 0) dAckCyc = c;
        dDone++;
      end
      nextCycle();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    checkOutput("trafficDone", 32'((ifDone >= nIf) && (dDone >= nD)), 32'd1);
  endtask

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perfIf0, perfD0;
`endif

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    memRdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstMemEn", bus.mem_en, 32'd0);
    checkOutput("rstIfRdata", bus.if_rdata, 32'd0);
    checkOutput("rstDAck", bus.d_ack, 32'd0);
    nextCycle();
    rst = 1'b0;
    nextCycle();

    // Lone fetch.
    runTraffic(1, 32'h100, 0, 1'b0, '0, '0);
    checkOutput("s1EnCount", enQ.size(), 32'd1);
    checkOutput("s1EnCycle", enQ[0], 32'd1);
    checkOutput("s1AckCycle", ifAckCyc, 32'd4);
    checkOutput("s1Rdata", bus.if_rdata, 32'hDEADBEEF);
    repeat (2) nextCycle();

    // Simultaneous fetch and load: D first.
`ifdef ARB_PERF_CNT_EN
    perfIf0 = perfIfWait; perfD0 = perfDWait;
`endif
    runTraffic(1, 32'h140, 1, 1'b0, 32'h200, '0);
    checkOutput("s2DAckCycle", dAckCyc, 32'd4);
    checkOutput("s2IfEnCycle", enQ[1], 32'd6);
    checkOutput("s2IfAckCycle", ifAckCyc, 32'd9);
    checkOutput("s2DRdata", bus.d_rdata, 32'h0200FDFF);
`ifdef ARB_PERF_CNT_EN
    checkOutput("s2PerfIf", perfIfWait - perfIf0, 32'd9);
    checkOutput("s2PerfD", perfDWait - perfD0, 32'd4);
`endif
    repeat (2) nextCycle();

    // Six back-to-back stores against a waiting fetch.
    runTraffic(1, 32'h180, 6, 1'b1, 32'h500, 32'h7000);
    checkOutput("s3Grants", enQ.size(), 32'd7);
    checkOutput("s3DBeforeIf", dBeforeIf, 32'd4);
    checkOutput("s3WeLastD", weQ[3], 32'd1);
    checkOutput("s3WeIf", weQ[4], 32'd0);
    checkOutput("s3IfAddr", addrQ[4], 32'h180);
    repeat (2) nextCycle();

    // Single store, then read it back.
    runTraffic(0, '0, 1, 1'b1, 32'h40, 32'h1234);
    checkOutput("s4We", weQ[0], 32'd1);
    checkOutput("s4Addr", addrQ[0], 32'h40);
    checkOutput("s4Wdata", wdataQ[0], 32'h1234);
    checkOutput("s4AckCycle", dAckCyc, 32'd4);
    checkOutput("s4DRdataKept", bus.d_rdata, 32'h0200FDFF);
    runTraffic(0, '0, 1, 1'b0, 32'h40, '0);
    checkOutput("s4ReadBack", bus.d_rdata, 32'h1234);
    repeat (2) nextCycle();

    // Reset while the fetch is waiting on memory.
    applyStimulus(1'b1, 32'h380, 1'b0, 1'b0, '0, '0);
    nextCycle();
    nextCycle();
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("s5MemEn", bus.mem_en, 32'd0);
    checkOutput("s5MemWe", bus.mem_we, 32'd0);
    checkOutput("s5MemAddr", bus.mem_addr, 32'd0);
    checkOutput("s5MemWdata", bus.mem_wdata, 32'd0);
    checkOutput("s5IfAck", bus.if_ack, 32'd0);
    checkOutput("s5IfRdata", bus.if_rdata, 32'd0);
    checkOutput("s5DRdata", bus.d_rdata, 32'd0);
    nextCycle();
    repeat (5) nextCycle();
    runTraffic(1, 32'h300, 0, 1'b0, '0, '0);
    checkOutput("s5AckCycle", ifAckCyc, 32'd4);
    checkOutput("s5Rdata", bus.if_rdata, 32'h0300FCFF);
    repeat (3) nextCycle();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
